// File: rtl/aes_key_ctx_controller_pkg.sv
// ---------------------------------------------------------------------------
// aes_key_ctx_controller_pkg
// Shared types and helpers for the AES key-context front-end controller:
//   - aes_ctrl_state_t : controller FSM states
//   - AES_BLOCK_W      : width of a key or data block
//   - aes_pkt_t        : in/out packet (block, mode, context id)
//   - sbox / rcon      : byte substitution and round constant for the
//                        AES-128 key schedule
// ---------------------------------------------------------------------------
package aes_key_ctx_controller_pkg;

   localparam int AES_BLOCK_W  = 128;
   localparam int NUM_CTX_DEF  = 4;
   localparam int PKT_CTX_W    = (NUM_CTX_DEF > 1) ? $clog2(NUM_CTX_DEF) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      KEY_GEN = 2'd1,
      PROCESS = 2'd2
   } aes_ctrl_state_t;

   typedef struct packed {
      logic [AES_BLOCK_W-1:0] data;
      logic                   en_de;
      logic [PKT_CTX_W-1:0]   ctx;
   } aes_pkt_t;

   // Forward S-box, element 0 first.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   // Round constant: 0x01 doubled in GF(2^8) once per round after the first.
   function automatic logic [7:0] rcon(input int r);
      logic [7:0] c;
      c = 8'h01;
      for (int i = 2; i <= 15; i++) begin
         if (i <= r) c = {c[6:0], 1'b0} ^ (c[7] ? 8'h1b : 8'h00);
      end
      return c;
   endfunction

endpackage

// File: rtl/aes_key_ctx_controller_key_expansion_stage.sv
// ---------------------------------------------------------------------------
// key_expansion_stage
// One combinational step of the AES-128 key schedule: derives round key
// round_idx from the previous round key.
// Ports:
//   round_idx : index of the round key being produced (1..NUM_ROUNDS)
//   in_key    : previous round key
//   out_key   : next round key
// ---------------------------------------------------------------------------
module key_expansion_stage
   import aes_key_ctx_controller_pkg::*;
#(
   parameter int RW = 4
) (
   input  logic [RW-1:0]          round_idx,
   input  logic [AES_BLOCK_W-1:0] in_key,
   output logic [AES_BLOCK_W-1:0] out_key
);

   logic [31:0] w0, w1, w2, w3, temp, n0, n1, n2, n3;

   assign w0 = in_key[127:96];
   assign w1 = in_key[95:64];
   assign w2 = in_key[63:32];
   assign w3 = in_key[31:0];

   // SubWord(RotWord(w3)) xor Rcon
   assign temp = {sbox(w3[23:16]) ^ rcon(int'(round_idx)),
                  sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};

   assign n0 = w0 ^ temp;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   assign out_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_ctx_controller.sv
// ---------------------------------------------------------------------------
// aes_key_ctx_controller
// Front-end controller between the input FIFO and the AES round pipeline.
// Key beats trigger iterative round-key expansion written into one of
// NUM_CTX key contexts; data beats pass through a registered, back-pressured
// output stage tagged with their context id.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready          : input handshake
//   in_data/in_set_key/in_en_de/in_ctx : input beat fields
//   out_valid/out_ready        : output handshake
//   out_data/out_en_de/out_ctx : forwarded data beat
//   key_out/key_wr_onehot/key_wr_ctx : round-key write port
//   key_busy                   : expansion in progress
//   err_unkeyed                : dropped-beat pulse
// Optional feature macro: AES_CTRL_CTX_VALID_EN (per-context valid bitmap;
// beats to unkeyed contexts are dropped and flagged on err_unkeyed).
// ---------------------------------------------------------------------------
module aes_key_ctx_controller
   import aes_key_ctx_controller_pkg::*;
#(
   parameter  int NUM_ROUNDS = 10,
   parameter  int NUM_CTX    = 4,
   localparam int CTX_W      = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_BLOCK_W-1:0] in_data,
   input  logic                   in_set_key,
   input  logic                   in_en_de,
   input  logic [CTX_W-1:0]       in_ctx,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_BLOCK_W-1:0] out_data,
   output logic                   out_en_de,
   output logic [CTX_W-1:0]       out_ctx,
   output logic [AES_BLOCK_W-1:0] key_out,
   output logic [NUM_ROUNDS:0]    key_wr_onehot,
   output logic [CTX_W-1:0]       key_wr_ctx,
   output logic                   key_busy,
   output logic                   err_unkeyed
);

   localparam int RW = $clog2(NUM_ROUNDS + 1);
   localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS);

   aes_ctrl_state_t state, state_next;
   logic [RW-1:0]          round_cnt;
   logic [AES_BLOCK_W-1:0] next_key;
   logic accept, key_acc, data_acc, drop, last_write;

   assign in_ready   = (state != KEY_GEN) && (!out_valid || out_ready);
   assign accept     = in_valid && in_ready;
   assign key_acc    = accept && in_set_key;
   assign data_acc   = accept && !in_set_key;
   assign last_write = (state == KEY_GEN) && (round_cnt == LAST_ROUND);
   assign key_busy   = (state == KEY_GEN);

   key_expansion_stage #(.RW(RW)) u_key_exp (
      .round_idx (round_cnt + RW'(1)),
      .in_key    (key_out),
      .out_key   (next_key)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic; the last round strobe hands over to PROCESS
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (key_acc) state_next = KEY_GEN;
         KEY_GEN: if (round_cnt == LAST_ROUND) state_next = PROCESS;
         PROCESS: if (key_acc) state_next = KEY_GEN;
         default: state_next = IDLE;
      endcase
   end

   // Round-key write port: round 0 is the cipher key itself, each following
   // cycle feeds the previous round key back through the expansion stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_out       <= '0;
         key_wr_onehot <= '0;
         key_wr_ctx    <= '0;
         round_cnt     <= '0;
      end else if (key_acc) begin
         key_out       <= in_data;
         key_wr_onehot <= (NUM_ROUNDS+1)'(1);
         key_wr_ctx    <= in_ctx;
         round_cnt     <= '0;
      end else if (state == KEY_GEN) begin
         if (round_cnt == LAST_ROUND) begin
            key_wr_onehot <= '0;
            round_cnt     <= '0;
         end else begin
            key_out       <= next_key;
            key_wr_onehot <= key_wr_onehot << 1;
            round_cnt     <= round_cnt + RW'(1);
         end
      end
   end

   // Output register: a new beat overwrites a draining one with no bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_en_de <= 1'b0;
         out_ctx   <= '0;
      end else if (data_acc && !drop) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
         out_en_de <= in_en_de;
         out_ctx   <= in_ctx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_en_de <= 1'b0;
         out_ctx   <= '0;
      end
   end

`ifdef AES_CTRL_CTX_VALID_EN
   logic [NUM_CTX-1:0] ctx_valid;
   logic               ctx_ok;
   logic               err_reg;

   // Out-of-range ids never match a context, so they count as unkeyed
   always_comb begin
      ctx_ok = 1'b0;
      for (int i = 0; i < NUM_CTX; i++) begin
         if (in_ctx == CTX_W'(i) && ctx_valid[i]) ctx_ok = 1'b1;
      end
   end

   assign drop = data_acc && !ctx_ok;

   // Context becomes valid once its last round key is written and is
   // invalidated as soon as a reload of it begins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctx_valid <= '0;
         err_reg   <= 1'b0;
      end else begin
         err_reg <= drop;
         for (int i = 0; i < NUM_CTX; i++) begin
            if (key_acc && in_ctx == CTX_W'(i))
               ctx_valid[i] <= 1'b0;
            else if (last_write && key_wr_ctx == CTX_W'(i))
               ctx_valid[i] <= 1'b1;
         end
      end
   end

   assign err_unkeyed = err_reg;
`else
   logic unused_last;
   assign unused_last = last_write;
   assign drop        = 1'b0;
   assign err_unkeyed = 1'b0;
`endif

endmodule

// File: tb/tb_aes_key_ctx_controller.sv
// ---------------------------------------------------------------------------
// tb_aes_key_ctx_controller
// Self-checking bench for aes_key_ctx_controller: reset state, FIPS-197
// key schedule on ctx 2, a table of data-path vectors, stall, key behind a
// stalled beat, reset during expansion and (with AES_CTRL_CTX_VALID_EN)
// dropping of beats to unkeyed contexts.
// ---------------------------------------------------------------------------
module tb_aes_key_ctx_controller;

   localparam logic [127:0] KEY0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] DA    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] DB    = 128'hdeadbeefcafef00d0123456789abcdef;
   localparam logic [127:0] DC    = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] DD    = 128'h55555555aaaaaaaa33333333cccccccc;
   localparam logic [127:0] DE    = 128'h11111111222222223333333344444444;
   localparam logic [127:0] DF    = 128'h99999999888888887777777766666666;
   localparam logic [127:0] DG    = 128'hfedcba98765432100123456789abcdef;
   localparam logic [127:0] KEY2  = 128'h000102030405060708090a0b0c0d0e0f;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, in_set_key, in_en_de;
   logic [127:0] in_data;
   logic [1:0]   in_ctx;
   logic         out_valid, out_ready, out_en_de;
   logic [127:0] out_data;
   logic [1:0]   out_ctx;
   logic [127:0] key_out;
   logic [10:0]  key_wr_onehot;
   logic [1:0]   key_wr_ctx;
   logic         key_busy, err_unkeyed;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   aes_key_ctx_controller dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_set_key(in_set_key), .in_en_de(in_en_de), .in_ctx(in_ctx),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_en_de(out_en_de), .out_ctx(out_ctx),
      .key_out(key_out), .key_wr_onehot(key_wr_onehot),
      .key_wr_ctx(key_wr_ctx), .key_busy(key_busy), .err_unkeyed(err_unkeyed)
   );

   typedef struct {
      logic         valid;
      logic         set_key;
      logic         en_de;
      logic [1:0]   ctx;
      logic [127:0] data;
      logic         ordy;
      logic         exp_ready;
      logic         exp_ovalid;
      logic [127:0] exp_odata;
      logic         exp_en;
      logic [1:0]   exp_ctx;
   } vec_t;

   vec_t vecs[10];

   task automatic applyStimulus(input logic v, input logic sk, input logic en,
                                input logic [1:0] c, input logic [127:0] d,
                                input logic ordy);
      in_valid   = v;
      in_set_key = sk;
      in_en_de   = en;
      in_ctx     = c;
      in_data    = d;
      out_ready  = ordy;
   endtask

   task automatic checkOutput(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Loads a key and waits, bounded, for the expansion to finish
   task automatic loadKey(input logic [1:0] c, input logic [127:0] k);
      int n;
      applyStimulus(1'b1, 1'b1, 1'b0, c, k, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b1);
      n = 0;
      while (key_busy && n < 30) begin
         tick();
         n++;
      end
      checkOutput("loadKey_done", {127'd0, key_busy}, 128'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vecs[0] = '{1'b1,1'b0,1'b1,2'd1,DA,1'b1, 1'b1,1'b1,DA,1'b1,2'd1};
      vecs[1] = '{1'b1,1'b0,1'b0,2'd3,DB,1'b1, 1'b1,1'b1,DB,1'b0,2'd3};
      vecs[2] = '{1'b1,1'b0,1'b1,2'd0,DC,1'b0, 1'b0,1'b1,DB,1'b0,2'd3};
      vecs[3] = '{1'b1,1'b0,1'b1,2'd0,DC,1'b0, 1'b0,1'b1,DB,1'b0,2'd3};
      vecs[4] = '{1'b1,1'b0,1'b1,2'd0,DC,1'b1, 1'b1,1'b1,DC,1'b1,2'd0};
      vecs[5] = '{1'b0,1'b0,1'b0,2'd0,DD,1'b1, 1'b1,1'b0,'0,1'b0,2'd0};
      vecs[6] = '{1'b0,1'b0,1'b0,2'd0,DD,1'b0, 1'b1,1'b0,'0,1'b0,2'd0};
      vecs[7] = '{1'b1,1'b0,1'b0,2'd2,DD,1'b0, 1'b1,1'b1,DD,1'b0,2'd2};
      vecs[8] = '{1'b0,1'b0,1'b0,2'd0,DA,1'b0, 1'b0,1'b1,DD,1'b0,2'd2};
      vecs[9] = '{1'b0,1'b0,1'b0,2'd0,DA,1'b1, 1'b1,1'b0,'0,1'b0,2'd0};

      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b1);
      #12 rst_n = 1'b1;
      #1;

      // Reset state
      checkOutput("rst_out_valid", {127'd0, out_valid}, 128'd0);
      checkOutput("rst_in_ready", {127'd0, in_ready}, 128'd1);
      checkOutput("rst_onehot", {117'd0, key_wr_onehot}, 128'd0);
      checkOutput("rst_key_out", key_out, 128'd0);
      checkOutput("rst_busy_err", {126'd0, key_busy, err_unkeyed}, 128'd0);
      checkOutput("rst_out_data", out_data, 128'd0);

      // FIPS-197 key on ctx 2
      applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, KEY0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b1);
      checkOutput("kg_r0_key", key_out, KEY0);
      checkOutput("kg_r0_onehot", {117'd0, key_wr_onehot}, 128'd1);
      checkOutput("kg_r0_ctx_busy", {125'd0, key_wr_ctx, key_busy}, {125'd0, 2'd2, 1'b1});
      checkOutput("kg_r0_ready", {127'd0, in_ready}, 128'd0);
      for (int r = 1; r <= 10; r++) begin
         tick();
         checkOutput("kg_onehot", {117'd0, key_wr_onehot}, 128'd1 << r);
         checkOutput("kg_ready_ctx", {125'd0, in_ready, key_wr_ctx}, {125'd0, 1'b0, 2'd2});
         if (r == 1)  checkOutput("kg_r1_key", key_out, RK1);
         if (r == 10) checkOutput("kg_r10_key", key_out, RK10);
      end
      tick();
      checkOutput("kg_end_onehot", {117'd0, key_wr_onehot}, 128'd0);
      checkOutput("kg_end_busy_ready", {126'd0, key_busy, in_ready}, 128'd1);
      checkOutput("kg_end_ctx_hold", {126'd0, key_wr_ctx}, 128'd2);

`ifdef AES_CTRL_CTX_VALID_EN
      loadKey(2'd0, KEY2);
      loadKey(2'd1, KEY2);
      loadKey(2'd3, KEY2);
`endif

      // Data-path vector table
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].valid, vecs[i].set_key, vecs[i].en_de,
                       vecs[i].ctx, vecs[i].data, vecs[i].ordy);
         #1;
         checkOutput("vec_in_ready", {127'd0, in_ready}, {127'd0, vecs[i].exp_ready});
         tick();
         checkOutput("vec_out_valid", {127'd0, out_valid}, {127'd0, vecs[i].exp_ovalid});
         checkOutput("vec_out_data", out_data, vecs[i].exp_odata);
         checkOutput("vec_out_en_ctx", {125'd0, out_en_de, out_ctx},
                     {125'd0, vecs[i].exp_en, vecs[i].exp_ctx});
      end

      // Five-cycle stall with in_valid held high
      applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, DE, 1'b0);
      tick();
      checkOutput("stall_first", out_data, DE);
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd2, DF, 1'b0);
      for (int c = 0; c < 5; c++) begin
         #1;
         checkOutput("stall_ready", {127'd0, in_ready}, 128'd0);
         tick();
         checkOutput("stall_hold", out_data, DE);
         checkOutput("stall_valid_tag", {124'd0, out_valid, out_en_de, out_ctx},
                     {124'd0, 1'b1, 1'b1, 2'd1});
      end
      out_ready = 1'b1;
      #1;
      checkOutput("stall_release_ready", {127'd0, in_ready}, 128'd1);
      tick();
      checkOutput("stall_next_beat", out_data, DF);
      checkOutput("stall_next_tag", {125'd0, out_en_de, out_ctx}, {125'd0, 1'b0, 2'd2});
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b1);
      tick();
      checkOutput("stall_drained", {127'd0, out_valid}, 128'd0);

      // Key beat behind a stalled data beat
      applyStimulus(1'b1, 1'b0, 1'b1, 2'd2, DG, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 2'd3, KEY2, 1'b0);
      for (int c = 0; c < 2; c++) begin
         #1;
         checkOutput("kstall_ready", {127'd0, in_ready}, 128'd0);
         tick();
         checkOutput("kstall_no_key", {116'd0, key_busy, key_wr_onehot}, 128'd0);
         checkOutput("kstall_held", out_data, DG);
      end
      out_ready = 1'b1;
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b1);
      checkOutput("kstall_key_r0", key_out, KEY2);
      checkOutput("kstall_busy_ctx", {125'd0, key_busy, key_wr_ctx}, {125'd0, 1'b1, 2'd3});
      for (int r = 1; r <= 11; r++) begin
         checkOutput("kstall_no_out", {127'd0, out_valid}, 128'd0);
         tick();
      end
      checkOutput("kstall_done", {116'd0, key_busy, key_wr_onehot}, 128'd0);

      // Reset asserted at the round-5 strobe
      applyStimulus(1'b1, 1'b1, 1'b0, 2'd1, KEY0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b1);
      repeat (5) tick();
      checkOutput("rst5_onehot_before", {117'd0, key_wr_onehot}, 128'd32);
      rst_n = 1'b0;
      #1;
      checkOutput("rst5_onehot_async", {117'd0, key_wr_onehot}, 128'd0);
      checkOutput("rst5_busy_async", {127'd0, key_busy}, 128'd0);
      #1 rst_n = 1'b1;
      #1;
      checkOutput("rst5_ready", {127'd0, in_ready}, 128'd1);
      tick();
      checkOutput("rst5_idle", {116'd0, key_busy, key_wr_onehot}, 128'd0);
      checkOutput("rst5_key_cleared", key_out, 128'd0);

`ifdef AES_CTRL_CTX_VALID_EN
      // Beat to unkeyed ctx 1 is dropped, forwarded after ctx 1 is keyed
      applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, DA, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b1);
      checkOutput("unkeyed_err", {127'd0, err_unkeyed}, 128'd1);
      checkOutput("unkeyed_dropped", {127'd0, out_valid}, 128'd0);
      tick();
      checkOutput("unkeyed_err_pulse", {127'd0, err_unkeyed}, 128'd0);
      loadKey(2'd1, KEY0);
      applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, DA, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b1);
      checkOutput("keyed_err", {127'd0, err_unkeyed}, 128'd0);
      checkOutput("keyed_fwd_valid", {127'd0, out_valid}, 128'd1);
      checkOutput("keyed_fwd_data", out_data, DA);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
